apb_slv_regbank: RTL and testbench

// - APB3 completer (slave) answering the team's APB initiator: decodes PSEL/PENABLE/PWRITE/PADDR.
// - Owns a bank of R/W word registers plus one read-only status word.
// - Inserts wait states and flags bad accesses with PSLVERR.
// - Sits on the peripheral side of the APB bus, one instance per peripheral.

---
 rtl/apb_slv_pkg.sv | 17 +
 rtl/apb_slv_regfile.sv | 41 ++++
 rtl/apb_slv_regbank.sv | 144 ++++++++++++++
 tb/tb_apb_slv_regbank.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types, bus widths and address decode helper for the APB register bank.
package apb_slv_pkg;

    localparam int APB_AW = 16;
    localparam int APB_DW = 32;

    // Default map: eight R/W words followed by STATUS at 0x20.
    localparam logic [APB_AW-1:0] STATUS_OFS = 16'h0020;
    localparam int DEF_NUM_REGS = int'(STATUS_OFS) / 4;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

    function automatic logic [APB_AW-3:0] addr_to_word(input logic [APB_AW-1:0] addr);
        return addr[APB_AW-1:2];
    endfunction

endpackage

// File: rtl/apb_slv_regfile.sv
// NUM_REGS x 32-bit register file: one write port, asynchronous read mux, register 0 tap.
module apb_slv_regfile
    import apb_slv_pkg::*;
#(
    parameter int                NUM_REGS  = DEF_NUM_REGS,
    parameter logic [APB_DW-1:0] RESET_VAL = '0,
    parameter int                IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              pclk,
    input  logic              prst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [APB_DW-1:0] wdata,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [APB_DW-1:0] rdata,
    output logic [APB_DW-1:0] reg0
);

    logic [APB_DW-1:0] regs [NUM_REGS];

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx == IDX_W'(i)) regs[i] <= wdata;
            end
        end
    end

    // Loop mux keeps non-power-of-two sizes free of out-of-range indexing.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) rdata = regs[i];
        end
    end

    assign reg0 = regs[0];

endmodule

// File: rtl/apb_slv_regbank.sv
// APB3 completer with R/W register bank and read-only STATUS word.
// Define APB_SLV_WAIT_EN to insert WAIT_CYCLES PREADY-low cycles per access.
//
// state  | meaning
// IDLE   | no transfer; waiting for psel_i & ~penable_i
// SETUP  | setup seen; decode and read data captured on exit
// ACCESS | response phase; pready_o rises once the wait count expires
module apb_slv_regbank
    import apb_slv_pkg::*;
#(
    parameter int                NUM_REGS    = DEF_NUM_REGS,
    parameter logic [APB_DW-1:0] RESET_VAL   = '0,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic              pclk_i,
    input  logic              prst_n_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [APB_AW-1:0] paddr_i,
    input  logic [APB_DW-1:0] pwdata_i,
    output logic [APB_DW-1:0] prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    input  logic [APB_DW-1:0] status_i,
    output logic [APB_DW-1:0] ctrl_o
);

    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int WORD_W = APB_AW - 2;
    localparam logic [WORD_W-1:0] STATUS_WORD = WORD_W'(NUM_REGS);

`ifdef APB_SLV_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif
    localparam logic [3:0] WAIT_LOAD = WAIT_EN ? 4'(WAIT_CYCLES) : 4'd0;

    apb_state_t        state_q, state_d;
    logic [WORD_W-1:0] word;
    logic              hit_status, dec_err;
    logic [APB_DW-1:0] reg_rdata, rd_mux;
    logic              we_q, err_q;
    logic [IDX_W-1:0]  idx_q;
    logic              start, done, commit, rdy_d;

    // Whole word index is compared, so any stray upper address bit decodes as an error.
    assign word       = addr_to_word(paddr_i);
    assign hit_status = (word == STATUS_WORD);
    assign dec_err    = (|paddr_i[1:0]) | (word > STATUS_WORD) | (pwrite_i & hit_status);
    assign rd_mux     = (pwrite_i | dec_err) ? '0 : (hit_status ? status_i : reg_rdata);

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel_i & ~penable_i) state_d = SETUP;
            end
            SETUP: begin
                if (psel_i) begin
                    state_d = ACCESS;
                    start   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (!psel_i) begin
                    state_d = IDLE;
                end else if (penable_i & pready_o) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign commit = done & we_q & ~err_q;

`ifdef APB_SLV_WAIT_EN
    logic [3:0] wait_cnt_q;

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i)              wait_cnt_q <= '0;
        else if (start)             wait_cnt_q <= WAIT_LOAD;
        else if (state_d != ACCESS) wait_cnt_q <= '0;
        else if (wait_cnt_q != 4'd0) wait_cnt_q <= wait_cnt_q - 4'd1;
    end

    assign rdy_d = start ? (WAIT_LOAD == 4'd0) : (pready_o | (wait_cnt_q == 4'd1));
`else
    assign rdy_d = start ? (WAIT_LOAD == 4'd0) : 1'b1;
`endif

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            prdata_o  <= '0;
            pready_o  <= 1'b0;
            pslverr_o <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
        end else if (start) begin
            we_q      <= pwrite_i;
            err_q     <= dec_err;
            idx_q     <= word[IDX_W-1:0];
            prdata_o  <= rd_mux;
            pready_o  <= rdy_d;
            pslverr_o <= rdy_d & dec_err;
        end else if (state_d == ACCESS) begin
            pready_o  <= rdy_d;
            pslverr_o <= rdy_d & err_q;
        end else begin
            prdata_o  <= '0;
            pready_o  <= 1'b0;
            pslverr_o <= 1'b0;
        end
    end

    apb_slv_regfile #(
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (RESET_VAL),
        .IDX_W     (IDX_W)
    ) u_regfile (
        .pclk   (pclk_i),
        .prst_n (prst_n_i),
        .we     (commit),
        .idx    (idx_q),
        .wdata  (pwdata_i),
        .rd_idx (word[IDX_W-1:0]),
        .rdata  (reg_rdata),
        .reg0   (ctrl_o)
    );

endmodule

// File: tb/tb_apb_slv_regbank.sv
// Self-checking bench for apb_slv_regbank: directed cases plus randomized traffic vs. a register-map model.
module tb_apb_slv_regbank;

    localparam int NREGS = 8;
    localparam int STAT_ADDR = 32;
`ifdef APB_SLV_WAIT_EN
    localparam int EXP_CYC = 4;
`else
    localparam int EXP_CYC = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [15:0] paddr = '0;
    logic [31:0] pwdata = '0, status = '0;
    logic [31:0] prdata, ctrl;
    logic        pready, pslverr;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] mregs [NREGS];

    apb_slv_regbank dut (
        .pclk_i    (clk),
        .prst_n_i  (rst_n),
        .psel_i    (psel),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .paddr_i   (paddr),
        .pwdata_i  (pwdata),
        .prdata_o  (prdata),
        .pready_o  (pready),
        .pslverr_o (pslverr),
        .status_i  (status),
        .ctrl_o    (ctrl)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic exp_err(input logic wr, input logic [15:0] a);
        int w = int'(a) / 4;
        return (int'(a) % 4 != 0) || (w > NREGS) || (wr && w == NREGS);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic wr, input logic [15:0] a);
        int w = int'(a) / 4;
        if (wr || exp_err(wr, a)) return 32'h0;
        if (w == NREGS) return status;
        return mregs[w];
    endfunction

    task automatic model_apply(input logic wr, input logic [15:0] a, input logic [31:0] d);
        if (wr && !exp_err(wr, a) && int'(a) / 4 < NREGS) mregs[int'(a) / 4] = d;
    endtask

    // Called at posedge+1; returns at posedge+1 after the completion edge with the bus released.
    task automatic apb_xfer(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err, output int ncyc,
                            output logic tmo, output logic [31:0] ctrl_at_rdy);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        ncyc = 0; tmo = 1'b0;
        forever begin
            ncyc++;
            @(negedge clk);
            if (pready === 1'b1) break;
            if (ncyc >= 40) begin tmo = 1'b1; break; end
            @(posedge clk); #1;
        end
        rd = prdata; err = pslverr; ctrl_at_rdy = ctrl;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        psel = 1'b0; penable = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < NREGS; i++) mregs[i] = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] rd, cr; logic err, tmo; int nc;
        do_reset();
        @(negedge clk);
        n_cmp++;
        if ({pready, pslverr, prdata, ctrl} !== 66'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got pready=%b pslverr=%b prdata=%h ctrl=%h, want all 0", pready, pslverr, prdata, ctrl);
        end
        @(posedge clk); #1;
        for (int i = 0; i < NREGS; i++) begin
            apb_xfer(1'b0, 16'(i * 4), 32'h0, rd, err, nc, tmo, cr);
            n_cmp++;
            if (rd !== 32'h0 || err !== 1'b0) begin
                n_err++;
                $display("FAIL reset_regval[%0d]: got %h err=%b, want 00000000 err=0", i, rd, err);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd, cr; logic err, tmo; int nc;
        apb_xfer(1'b1, 16'h0004, 32'h00CC_BBAA, rd, err, nc, tmo, cr);
        model_apply(1'b1, 16'h0004, 32'h00CC_BBAA);
        n_cmp++;
        if (err !== 1'b0 || nc !== EXP_CYC || tmo !== 1'b0) begin
            n_err++;
            $display("FAIL wr_0004: got err=%b cycles=%0d tmo=%b, want err=0 cycles=%0d tmo=0", err, nc, tmo, EXP_CYC);
        end
        apb_xfer(1'b0, 16'h0004, 32'h0, rd, err, nc, tmo, cr);
        n_cmp++;
        if (rd !== 32'h00CC_BBAA || err !== 1'b0 || nc !== EXP_CYC) begin
            n_err++;
            $display("FAIL rd_0004: got %h err=%b cycles=%0d, want 00ccbbaa err=0 cycles=%0d", rd, err, nc, EXP_CYC);
        end
        apb_xfer(1'b1, 16'h0000, 32'h1234_5678, rd, err, nc, tmo, cr);
        model_apply(1'b1, 16'h0000, 32'h1234_5678);
        n_cmp++;
        if (cr !== 32'h0 || ctrl !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL ctrl_timing: got before=%h after=%h, want before=00000000 after=12345678", cr, ctrl);
        end
        apb_xfer(1'b0, 16'h0000, 32'h0, rd, err, nc, tmo, cr);
        n_cmp++;
        if (rd !== 32'h1234_5678 || err !== 1'b0) begin
            n_err++;
            $display("FAIL rd_0000: got %h err=%b, want 12345678 err=0", rd, err);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, cr; logic err, tmo; int nc;
        logic [15:0] bad [4];
        bad[0] = 16'hDDCC; bad[1] = 16'h0002; bad[2] = 16'h0104; bad[3] = 16'h0024;
        for (int i = 0; i < 4; i++) begin
            apb_xfer(1'b1, bad[i], 32'hFFFF_FFFF, rd, err, nc, tmo, cr);
            n_cmp++;
            if (err !== 1'b1 || nc !== EXP_CYC) begin
                n_err++;
                $display("FAIL err_wr[%h]: got err=%b cycles=%0d, want err=1 cycles=%0d", bad[i], err, nc, EXP_CYC);
            end
            apb_xfer(1'b0, bad[i], 32'h0, rd, err, nc, tmo, cr);
            n_cmp++;
            if (err !== 1'b1 || rd !== 32'h0) begin
                n_err++;
                $display("FAIL err_rd[%h]: got err=%b data=%h, want err=1 data=00000000", bad[i], err, rd);
            end
        end
        for (int i = 0; i < NREGS; i++) begin
            apb_xfer(1'b0, 16'(i * 4), 32'h0, rd, err, nc, tmo, cr);
            n_cmp++;
            if (rd !== mregs[i]) begin
                n_err++;
                $display("FAIL err_unchanged[%0d]: got %h, want %h", i, rd, mregs[i]);
            end
        end
    endtask

    task automatic test_status();
        logic [31:0] rd, cr; logic err, tmo; int nc;
        status = 32'hA5A5_0001;
        apb_xfer(1'b0, 16'h0020, 32'h0, rd, err, nc, tmo, cr);
        n_cmp++;
        if (rd !== 32'hA5A5_0001 || err !== 1'b0) begin
            n_err++;
            $display("FAIL status_rd: got %h err=%b, want a5a50001 err=0", rd, err);
        end
        @(negedge clk);
        n_cmp++;
        if ({pready, pslverr, prdata} !== 34'h0) begin
            n_err++;
            $display("FAIL idle_outputs: got pready=%b pslverr=%b prdata=%h, want all 0", pready, pslverr, prdata);
        end
        @(posedge clk); #1;
        apb_xfer(1'b1, 16'h0020, 32'h0BAD_0BAD, rd, err, nc, tmo, cr);
        n_cmp++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL status_wr: got err=%b, want err=1", err);
        end
    endtask

    task automatic test_penable_in_idle();
        logic [31:0] rd, cr; logic err, tmo; int nc; logic seen;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 16'h0000; pwdata = 32'h5555_AAAA;
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (pready !== 1'b0) seen = 1'b1; end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL penable_idle_ready: got pready seen=%b, want 0", seen);
        end
        apb_xfer(1'b0, 16'h0000, 32'h0, rd, err, nc, tmo, cr);
        n_cmp++;
        if (rd !== mregs[0]) begin
            n_err++;
            $display("FAIL penable_idle_nowrite: got %h, want %h", rd, mregs[0]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, cr; logic err, tmo; int nc; logic seen;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0008; pwdata = 32'hDEAD_0008;
        @(posedge clk); #1;
        psel = 1'b0; pwrite = 1'b0;
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (pready !== 1'b0) seen = 1'b1; end
        @(posedge clk); #1;
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_setup_ready: got pready seen=%b, want 0", seen);
        end
`ifdef APB_SLV_WAIT_EN
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h000C; pwdata = 32'hDEAD_000C;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(negedge clk); if (pready !== 1'b0) seen = 1'b1; end
        @(posedge clk); #1;
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_wait_ready: got pready seen=%b, want 0", seen);
        end
`endif
        apb_xfer(1'b0, 16'h0008, 32'h0, rd, err, nc, tmo, cr);
        n_cmp++;
        if (rd !== mregs[2] || nc !== EXP_CYC) begin
            n_err++;
            $display("FAIL abort_reg2: got %h cycles=%0d, want %h cycles=%0d", rd, nc, mregs[2], EXP_CYC);
        end
        apb_xfer(1'b0, 16'h000C, 32'h0, rd, err, nc, tmo, cr);
        n_cmp++;
        if (rd !== mregs[3] || nc !== EXP_CYC) begin
            n_err++;
            $display("FAIL abort_reg3: got %h cycles=%0d, want %h cycles=%0d", rd, nc, mregs[3], EXP_CYC);
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] rd, cr, wd, erd; logic err, tmo, wr, eerr; int nc;
        logic [15:0] a;
        for (int t = 0; t < n; t++) begin
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0, 1, 2: a = 16'($urandom_range(0, NREGS - 1) * 4);
                3:       a = 16'(STAT_ADDR);
                4:       a = 16'($urandom_range(0, NREGS - 1) * 4 + $urandom_range(1, 3));
                default: a = 16'($urandom);
            endcase
            wd = $urandom;
            status = $urandom;
            erd = exp_rdata(wr, a);
            eerr = exp_err(wr, a);
            apb_xfer(wr, a, wd, rd, err, nc, tmo, cr);
            model_apply(wr, a, wd);
            n_cmp++;
            if (rd !== erd || err !== eerr || nc !== EXP_CYC || tmo !== 1'b0 || ctrl !== mregs[0]) begin
                n_err++;
                $display("FAIL rand[%0d] %s %h: got data=%h err=%b cycles=%0d tmo=%b ctrl=%h, want data=%h err=%b cycles=%0d tmo=0 ctrl=%h",
                         t, wr ? "wr" : "rd", a, rd, err, nc, tmo, ctrl, erd, eerr, EXP_CYC, mregs[0]);
            end
            // Zero gap exercises back-to-back transfers.
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd, cr; logic err, tmo; int nc;
        apb_xfer(1'b1, 16'h0000, 32'hCAFE_F00D, rd, err, nc, tmo, cr);
        model_apply(1'b1, 16'h0000, 32'hCAFE_F00D);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0010; pwdata = 32'h7777_7777;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pready, pslverr, prdata, ctrl} !== 66'h0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got pready=%b pslverr=%b prdata=%h ctrl=%h, want all 0", pready, pslverr, prdata, ctrl);
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < NREGS; i++) mregs[i] = 32'h0;
        for (int i = 0; i < NREGS; i++) begin
            apb_xfer(1'b0, 16'(i * 4), 32'h0, rd, err, nc, tmo, cr);
            n_cmp++;
            if (rd !== 32'h0) begin
                n_err++;
                $display("FAIL rst_mid_reg[%0d]: got %h, want 00000000", i, rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_status();
        test_penable_in_idle();
        test_abort();
        test_random(200);
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
